// File: rtl/mips_hazard_pkg.sv
// Shared types and stall-length constants for the decode-stage branch hazard logic.
package mips_hazard_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } state_t;

  // Number of stall cycles a branch needs before its operands are available in ID.
  localparam logic [1:0] STALL_NONE     = 2'd0;
  localparam logic [1:0] STALL_ALU_EX   = 2'd1;
  localparam logic [1:0] STALL_LOAD_MEM = 2'd1;
  localparam logic [1:0] STALL_LOAD_EX  = 2'd2;

endpackage

// File: rtl/branch_operand_fwd.sv
// Forwarding mux for one branch operand: picks the MEM-stage ALU result when the
// instruction in MEM is a non-load register write to the same, non-zero register.
module branch_operand_fwd
  import mips_hazard_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] reg_id,
  input  logic [DATA_W-1:0]     reg_data,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_alu_result,
  output logic [DATA_W-1:0]     operand
);

  logic use_mem;

  // Register $0 is hard-wired, so it is never a forwarding target.
  assign use_mem = mem_reg_write && !mem_mem_to_reg &&
                   (mem_rd != '0) && (mem_rd == reg_id);
  assign operand = use_mem ? mem_alu_result : reg_data;

endmodule

// File: rtl/is_equal.sv
// Equality comparator of two LENGTH-bit words.
module is_equal #(
  parameter int LENGTH = 32
) (
  input  logic [LENGTH-1:0] a,
  input  logic [LENGTH-1:0] b,
  output logic              eq
);

  assign eq = (a == b);

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Decode-stage beq/bne controller: hazard stall sequencing, operand forwarding,
// branch resolution and saturating branch statistics.
module branch_hazard_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_branch_id,
  input  logic                  i_bne_id,
  input  logic [REG_ADDR_W-1:0] i_rs_id,
  input  logic [REG_ADDR_W-1:0] i_rt_id,
  input  logic [DATA_W-1:0]     i_rs_data,
  input  logic [DATA_W-1:0]     i_rt_data,
  input  logic                  i_ex_reg_write,
  input  logic                  i_ex_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_mem_reg_write,
  input  logic                  i_mem_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic [DATA_W-1:0]     i_mem_alu_result,
  input  logic                  i_kill,
  output logic                  o_stall,
  output logic                  o_bubble_idex,
  output logic                  o_pc_src,
  output logic                  o_flush_ifid,
  output logic [CNT_W-1:0]      o_branch_cnt,
  output logic [CNT_W-1:0]      o_taken_cnt,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] r,
                                     input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] rt);
    return (r != '0) && ((r == rs) || (r == rt));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  state_t               state;
  logic [1:0]           cnt;
  logic [1:0]           need;
  logic [1:0]           cnt_dec;
  logic                 m_ex;
  logic                 m_mem;
  logic [DATA_W-1:0]    op_a;
  logic [DATA_W-1:0]    op_b;
  logic                 eq;
  logic                 taken;
  logic                 stall;
  logic                 resolve;

  assign m_ex  = reg_match(i_ex_rd, i_rs_id, i_rt_id);
  assign m_mem = reg_match(i_mem_rd, i_rs_id, i_rt_id);

  // Stall length the branch in ID needs, worst hazard first.
  always_comb begin
    need = STALL_NONE;
    if (i_ex_reg_write && i_ex_mem_to_reg && m_ex)
      need = STALL_LOAD_EX;
    else if (i_ex_reg_write && m_ex)
      need = STALL_ALU_EX;
    else if (i_mem_reg_write && i_mem_mem_to_reg && m_mem)
      need = STALL_LOAD_MEM;
  end

  branch_operand_fwd #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .reg_id         (i_rs_id),
    .reg_data       (i_rs_data),
    .mem_reg_write  (i_mem_reg_write),
    .mem_mem_to_reg (i_mem_mem_to_reg),
    .mem_rd         (i_mem_rd),
    .mem_alu_result (i_mem_alu_result),
    .operand        (op_a)
  );

  branch_operand_fwd #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .reg_id         (i_rt_id),
    .reg_data       (i_rt_data),
    .mem_reg_write  (i_mem_reg_write),
    .mem_mem_to_reg (i_mem_mem_to_reg),
    .mem_rd         (i_mem_rd),
    .mem_alu_result (i_mem_alu_result),
    .operand        (op_b)
  );

  is_equal #(.LENGTH(DATA_W)) u_cmp (
    .a  (op_a),
    .b  (op_b),
    .eq (eq)
  );

  assign taken = eq ^ i_bne_id;

  // Per-cycle control decision; gated by rst_n so outputs drop the instant reset asserts.
  always_comb begin
    stall   = 1'b0;
    resolve = 1'b0;
    if (rst_n && !i_kill) begin
      if (state == S_STALL)
        stall = 1'b1;
      else if (i_branch_id) begin
        if (need != STALL_NONE) stall   = 1'b1;
        else                    resolve = 1'b1;
      end
    end
  end

  assign o_stall       = stall;
  assign o_bubble_idex = stall;
  assign o_pc_src      = resolve && taken;
  assign o_flush_ifid  = resolve && taken;

  // cnt holds the stall cycles still owed after the current one.
  assign cnt_dec = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;

  // Stall sequencer: IDLE issues the first stall cycle, STALL covers the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else if (i_kill) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_branch_id && (need != STALL_NONE)) begin
            cnt   <= need - 2'd1;
            state <= (need > 2'd1) ? S_STALL : S_IDLE;
          end
        end
        S_STALL: begin
          cnt   <= cnt_dec;
          state <= (cnt_dec == 2'd0) ? S_IDLE : S_STALL;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

  // Saturating statistics; a killed cycle has neither stall nor resolve, so nothing counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_branch_cnt <= '0;
      o_taken_cnt  <= '0;
      o_stall_cnt  <= '0;
    end else begin
      o_branch_cnt <= sat_inc(o_branch_cnt, resolve);
      o_taken_cnt  <= sat_inc(o_taken_cnt, resolve && taken);
      o_stall_cnt  <= sat_inc(o_stall_cnt, stall);
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Scoreboard bench for branch_hazard_ctrl: a behavioural model queues the expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_branch_hazard_ctrl;

  localparam int DW = 32;
  localparam int RA = 5;
  localparam int CW = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          branch, bne, ex_rw, ex_ld, mem_rw, mem_ld, kill;
  logic [RA-1:0] rs, rt, ex_rd, mem_rd;
  logic [DW-1:0] rs_data, rt_data, alu;
  logic          stall, bubble, pc_src, flush;
  logic [CW-1:0] bcnt, tcnt, scnt;

  typedef struct {
    string         name;
    logic [3:0]    ctrl;
    logic [CW-1:0] bc;
    logic [CW-1:0] tc;
    logic [CW-1:0] sc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model state: remaining stall cycles and counter values as plain integers.
  int m_rem = 0;
  int m_bc  = 0;
  int m_tc  = 0;
  int m_sc  = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.DATA_W(DW), .REG_ADDR_W(RA), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_branch_id      (branch),
    .i_bne_id         (bne),
    .i_rs_id          (rs),
    .i_rt_id          (rt),
    .i_rs_data        (rs_data),
    .i_rt_data        (rt_data),
    .i_ex_reg_write   (ex_rw),
    .i_ex_mem_to_reg  (ex_ld),
    .i_ex_rd          (ex_rd),
    .i_mem_reg_write  (mem_rw),
    .i_mem_mem_to_reg (mem_ld),
    .i_mem_rd         (mem_rd),
    .i_mem_alu_result (alu),
    .i_kill           (kill),
    .o_stall          (stall),
    .o_bubble_idex    (bubble),
    .o_pc_src         (pc_src),
    .o_flush_ifid     (flush),
    .o_branch_cnt     (bcnt),
    .o_taken_cnt      (tcnt),
    .o_stall_cnt      (scnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic uses(input logic [RA-1:0] r);
    return (r != 0) && (r == rs || r == rt);
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [RA-1:0] r, input logic [DW-1:0] d);
    if (mem_rw && !mem_ld && r != 0 && r == mem_rd) return alu;
    return d;
  endfunction

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic clear_in();
    branch = 0; bne = 0; rs = 0; rt = 0; rs_data = 0; rt_data = 0;
    ex_rw = 0; ex_ld = 0; ex_rd = 0; mem_rw = 0; mem_ld = 0; mem_rd = 0;
    alu = 0; kill = 0;
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, advance one cycle.
  task automatic step(input string name);
    exp_t          e;
    int            n;
    logic [DW-1:0] a, b;
    logic          tk;
    e.name = name;
    e.ctrl = 4'b0000;
    e.bc = CW'(m_bc); e.tc = CW'(m_tc); e.sc = CW'(m_sc);
    if (!rst_n) begin
      m_rem = 0; m_bc = 0; m_tc = 0; m_sc = 0;
      e.bc = 0; e.tc = 0; e.sc = 0;
    end else if (kill) begin
      m_rem = 0;
    end else if (m_rem > 0) begin
      e.ctrl = 4'b1100;
      m_rem--;
      m_sc = sat(m_sc);
    end else if (branch) begin
      n = 0;
      if (ex_rw && ex_ld && uses(ex_rd)) n = 2;
      else if ((ex_rw && uses(ex_rd)) || (mem_rw && mem_ld && uses(mem_rd))) n = 1;
      if (n > 0) begin
        e.ctrl = 4'b1100;
        m_rem = n - 1;
        m_sc = sat(m_sc);
      end else begin
        a = fwd(rs, rs_data);
        b = fwd(rt, rt_data);
        tk = (a == b) ^ bne;
        e.ctrl = {2'b00, tk, tk};
        m_bc = sat(m_bc);
        if (tk) m_tc = sat(m_tc);
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a decision every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.name, "_ctrl"}, 64'({stall, bubble, pc_src, flush}), 64'(e.ctrl));
      check({e.name, "_branch_cnt"}, 64'(bcnt), 64'(e.bc));
      check({e.name, "_taken_cnt"}, 64'(tcnt), 64'(e.tc));
      check({e.name, "_stall_cnt"}, 64'(scnt), 64'(e.sc));
    end
  end

  initial begin
    clear_in();
    rst_n = 0;
    @(posedge clk); #1;
    step("reset0");
    step("reset1");
    rst_n = 1;

    // beq $1,$2 with equal data, no hazard: taken in the same cycle
    clear_in(); branch = 1; rs = 1; rt = 2; rs_data = 5; rt_data = 5;
    step("beq_nohaz");
    clear_in(); step("idle_a");

    // bne $3,$4 behind an EX ALU write of $3: one stall, then MEM forwards 0x10
    clear_in(); branch = 1; bne = 1; rs = 3; rt = 4; rs_data = 32'h99; rt_data = 32'h10;
    ex_rw = 1; ex_rd = 3;
    step("bne_exalu_stall");
    ex_rw = 0; mem_rw = 1; mem_rd = 3; alu = 32'h10;
    step("bne_fwd_resolve");
    clear_in(); step("idle_b");

    // beq $5,$6 behind an EX load of $6: two stalls, then resolve
    clear_in(); branch = 1; rs = 5; rt = 6; rs_data = 7; rt_data = 7;
    ex_rw = 1; ex_ld = 1; ex_rd = 6;
    step("ld_stall1");
    ex_rw = 0; ex_ld = 0; mem_rw = 1; mem_ld = 1; mem_rd = 6;
    step("ld_stall2");
    mem_rw = 0; mem_ld = 0;
    step("ld_resolve");
    clear_in(); step("idle_c");

    // Register $0 never creates a hazard or forwards
    clear_in(); branch = 1; rs = 0; rt = 0; mem_rw = 1; mem_ld = 1; mem_rd = 0;
    step("r0_load_nostall");
    mem_ld = 0; alu = 32'hDEAD;
    step("r0_alu_nofwd");
    clear_in(); step("idle_d");

    // Kill on the cycle the load hazard is first seen
    clear_in(); branch = 1; rs = 5; rt = 6; ex_rw = 1; ex_ld = 1; ex_rd = 6; kill = 1;
    step("kill_detect");
    clear_in(); step("kill_after");
    // Kill while in the second stall cycle
    clear_in(); branch = 1; rs = 5; rt = 6; ex_rw = 1; ex_ld = 1; ex_rd = 6;
    step("kill2_stall1");
    clear_in(); kill = 1;
    step("kill2_in_stall");
    step("kill2_after");
    kill = 0;
    step("idle_e");

    // Asynchronous reset in the middle of a load stall
    clear_in(); branch = 1; rs = 5; rt = 6; ex_rw = 1; ex_ld = 1; ex_rd = 6;
    step("arst_stall1");
    rst_n = 0;
    #1;
    check("arst_stall_drop", 64'({stall, bubble, pc_src, flush}), 64'(0));
    check("arst_cnt_zero", 64'({bcnt, tcnt, scnt}), 64'(0));
    step("arst_held");
    rst_n = 1;
    step("arst_release");
    clear_in(); step("idle_f");

    // Randomised traffic over a small register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      branch = ($urandom_range(0, 3) != 0);
      bne    = $urandom_range(0, 1) == 1;
      rs     = RA'($urandom_range(0, 5));
      rt     = RA'($urandom_range(0, 5));
      rs_data = $urandom();
      rt_data = ($urandom_range(0, 1) == 1) ? rs_data : $urandom();
      ex_rw  = $urandom_range(0, 1) == 1;
      ex_ld  = $urandom_range(0, 2) == 0;
      ex_rd  = RA'($urandom_range(0, 7));
      mem_rw = $urandom_range(0, 1) == 1;
      mem_ld = $urandom_range(0, 2) == 0;
      mem_rd = RA'($urandom_range(0, 7));
      alu    = ($urandom_range(0, 1) == 1) ? rt_data : $urandom();
      kill   = ($urandom_range(0, 15) == 0);
      step("rand");
    end

    // Push the branch and taken counters into saturation
    clear_in(); branch = 1; rs = 1; rt = 2; rs_data = 3; rt_data = 3;
    for (int i = 0; i < CMAX + 8; i++) step("sat");
    clear_in(); branch = 1; bne = 1; rs = 1; rt = 2; rs_data = 3; rt_data = 3;
    step("sat_nottaken");
    clear_in(); step("sat_hold");
    step("sat_end");

    @(negedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
